// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle of the sequential Booth multiplier.
// The master drives the request and operands; the slave (the multiplier) returns status and the product.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle on operands extended by one bit,
// so the same signed datapath also serves unsigned multiplies. Fixed latency of WIDTH+1 cycles.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_seq_if.slave  bus
);

  localparam int N     = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [N-1:0]       a_q, a_d;
  logic signed [N-1:0]       m_q, m_d;
  logic        [N-1:0]       q_q, q_d;
  logic                      q1_q, q1_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [2*WIDTH-1:0] prod_q, prod_d;

  logic signed [N-1:0]       sum;
  logic        [2*N:0]       shifted;

  function automatic logic signed [N-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  function automatic logic signed [N-1:0] booth_add(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] m,
                                                    input logic [1:0]          pair);
    case (pair)
      2'b01:   return a + m;
      2'b10:   return a - m;
      default: return a;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    sum     = a_q;
    shifted = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = ext(bus.multiplicand, bus.signed_mode);
          q_d     = ext(bus.multiplier, bus.signed_mode);
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        sum     = booth_add(a_q, m_q, {q_q[0], q1_q});
        // Replicating sum's MSB in front and dropping the old Q-1 is the arithmetic shift of {A,Q,Q-1}.
        shifted = {sum[N-1], sum, q_q};
        a_d     = shifted[2*N:N+1];
        q_d     = shifted[N:1];
        q1_d    = shifted[0];
        cnt_d   = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          prod_d  = shifted[2*WIDTH:1];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH=8 and WIDTH=32: directed vector table, start/reset corner
// sequences and random operations compared against a plain-arithmetic product model.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8))  b8();
  booth_mult_seq_if #(.WIDTH(32)) b32();

  booth_mult_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  booth_mult_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));

  int errors = 0;
  int checks = 0;
  int acc8 = 0, acc32 = 0, dones8 = 0, dones32 = 0;

  always @(negedge clk) begin
    if (b8.done === 1'b1)  dones8++;
    if (b32.done === 1'b1) dones32++;
  end

  typedef struct {
    bit          sm;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input bit sm, input logic [7:0] m, input logic [7:0] q);
    longint a, b;
    a = sm ? longint'($signed(m)) : longint'(m);
    b = sm ? longint'($signed(q)) : longint'(q);
    return 16'(a * b);
  endfunction

  function automatic logic [63:0] ref32(input bit sm, input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] a, b;
    a = sm ? 64'($signed(m)) : {32'd0, m};
    b = sm ? 64'($signed(q)) : {32'd0, q};
    return a * b;
  endfunction

  // Called #1 after a clock edge with the DUT idle; returns #1 after the edge that raised done.
  task automatic op8(input bit sm, input logic [7:0] m, input logic [7:0] q,
                     output logic [15:0] p, output int lat);
    bit busy_ok = 1'b1;
    b8.start = 1'b1; b8.signed_mode = sm; b8.multiplicand = m; b8.multiplier = q;
    @(posedge clk); #1;
    acc8++;
    b8.start = 1'b0; b8.signed_mode = 1'($urandom);
    b8.multiplicand = 8'($urandom); b8.multiplier = 8'($urandom);
    lat = 0;
    while (b8.done !== 1'b1 && lat < 40) begin
      if (b8.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy8_during_calc", 64'(busy_ok), 64'd1);
    chk("busy8_at_done", 64'(b8.busy), 64'd0);
    p = b8.product;
  endtask

  task automatic op32(input bit sm, input logic [31:0] m, input logic [31:0] q,
                      output logic [63:0] p, output int lat);
    b32.start = 1'b1; b32.signed_mode = sm; b32.multiplicand = m; b32.multiplier = q;
    @(posedge clk); #1;
    acc32++;
    b32.start = 1'b0; b32.signed_mode = 1'($urandom);
    b32.multiplicand = $urandom; b32.multiplier = $urandom;
    lat = 0;
    while (b32.done !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    p = b32.product;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [15:0] p8, prev8;
    logic [63:0] p64, prev64;
    int          lat;
    bit          sm;
    logic [7:0]  m8, q8;
    logic [31:0] m32, q32;
    bit          no_done;

    vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[6] = '{1'b1, 8'h00, 8'h7F, 16'h0000};
    vecs[7] = '{1'b0, 8'h07, 8'h06, 16'h002A};

    b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.multiplicand = '0;  b8.multiplier = '0;
    b32.start = 1'b0; b32.signed_mode = 1'b0; b32.multiplicand = '0; b32.multiplier = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(b8.busy), 64'd0);
    chk("reset_done", 64'(b8.done), 64'd0);
    chk("reset_product", 64'(b8.product), 64'd0);
    chk("reset_product32", b32.product, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].sm, vecs[i].m, vecs[i].q, p8, lat);
      chk($sformatf("vec%0d_product", i), 64'(p8), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 64'(b8.done), 64'd0);
      chk($sformatf("vec%0d_product_held", i), 64'(b8.product), 64'(vecs[i].exp));
    end

    // start held high with changing operands during CALC and DONE
    b8.start = 1'b1; b8.signed_mode = 1'b0; b8.multiplicand = 8'd7; b8.multiplier = 8'd6;
    @(posedge clk); #1;
    acc8++;
    lat = 0;
    while (b8.done !== 1'b1 && lat < 40) begin
      b8.multiplicand = 8'($urandom); b8.multiplier = 8'($urandom); b8.signed_mode = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("held_start_latency", 64'(lat), 64'd9);
    chk("held_start_product", 64'(b8.product), 64'h002A);
    b8.multiplicand = 8'd3; b8.multiplier = 8'd5; b8.signed_mode = 1'b0;
    @(posedge clk); #1;
    chk("held_start_idle_busy", 64'(b8.busy), 64'd0);
    chk("held_start_idle_product", 64'(b8.product), 64'h002A);
    @(posedge clk); #1;
    acc8++;
    chk("held_start_second_accept", 64'(b8.busy), 64'd1);
    b8.start = 1'b0;
    lat = 0;
    while (b8.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("second_op_latency", 64'(lat), 64'd9);
    chk("second_op_product", 64'(b8.product), 64'h000F);
    @(posedge clk); #1;

    // Reset in the middle of CALC
    b8.start = 1'b1; b8.signed_mode = 1'b1; b8.multiplicand = 8'h85; b8.multiplier = 8'h3C;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_busy", 64'(b8.busy), 64'd0);
    chk("midreset_done", 64'(b8.done), 64'd0);
    chk("midreset_product", 64'(b8.product), 64'd0);
    no_done = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.done !== 1'b0 || b8.busy !== 1'b0) no_done = 1'b0;
    end
    chk("midreset_no_done_pulse", 64'(no_done), 64'd1);
    op8(1'b1, 8'hF9, 8'h0B, p8, lat);
    chk("after_reset_product", 64'(p8), 64'(ref8(1'b1, 8'hF9, 8'h0B)));
    chk("after_reset_latency", 64'(lat), 64'd9);
    @(posedge clk); #1;
    prev8 = p8;

    // Random regression, WIDTH=8
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      chk("rand8_idle_hold", 64'(b8.product), 64'(prev8));
      sm = 1'($urandom); m8 = 8'($urandom); q8 = 8'($urandom);
      if (i % 50 == 0) m8 = 8'h80;
      if (i % 70 == 0) q8 = 8'hFF;
      op8(sm, m8, q8, p8, lat);
      chk("rand8_product", 64'(p8), 64'(ref8(sm, m8, q8)));
      chk("rand8_latency", 64'(lat), 64'd9);
      @(posedge clk); #1;
      chk("rand8_done_pulse", 64'(b8.done), 64'd0);
      prev8 = p8;
    end

    // Random regression, WIDTH=32
    prev64 = b32.product;
    for (int i = 0; i < 700; i++) begin
      chk("rand32_idle_hold", b32.product, prev64);
      sm = 1'($urandom); m32 = $urandom; q32 = $urandom;
      if (i == 0) begin sm = 1'b1; m32 = 32'h8000_0000; q32 = 32'h8000_0000; end
      if (i == 1) begin sm = 1'b0; m32 = 32'hFFFF_FFFF; q32 = 32'hFFFF_FFFF; end
      if (i == 2) begin m32 = 32'd0; end
      op32(sm, m32, q32, p64, lat);
      chk("rand32_product", p64, ref32(sm, m32, q32));
      chk("rand32_latency", 64'(lat), 64'd33);
      @(posedge clk); #1;
      chk("rand32_done_pulse", 64'(b32.done), 64'd0);
      prev64 = p64;
    end

    chk("done_count8", 64'(dones8), 64'(acc8));
    chk("done_count32", 64'(dones32), 64'(acc32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
